// File: rtl/pc_fetch_stage.sv
// PC + instruction-fetch front end: one outstanding imem request, redirect-capable,
// one-entry {pc, instr} output register toward decode.
module pc_fetch_stage #(
  parameter int unsigned            ADDR_W   = 32,
  parameter int unsigned            INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              vld, vld_nxt;
  fetch_pkt_t        pkt, pkt_nxt;
  logic [ADDR_W-1:0] redir_pc;
  logic              req_hs;

  assign redir_pc       = redirect_pc & ~ADDR_W'(3);
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid & imem_req_ready;
  assign out_valid      = vld;
  assign out_pc         = pkt.pc;
  assign out_instr      = pkt.instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      vld   <= 1'b0;
      pkt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      vld   <= vld_nxt;
      pkt   <= pkt_nxt;
    end
  end

  // Redirect overrides every other transition; it only decides whether a
  // request is still in flight (-> DRAIN) or not (-> REQ).
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    vld_nxt   = vld;
    pkt_nxt   = pkt;
    unique case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redirect_valid) pc_nxt = redir_pc;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_nxt    = redir_pc;
          state_nxt = req_hs ? DRAIN : REQ;
        end else if (req_hs) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nxt    = redir_pc;
          state_nxt = imem_rsp_valid ? REQ : DRAIN;
        end else if (imem_rsp_valid) begin
          pkt_nxt   = '{pc: pc, instr: imem_rsp_data};
          vld_nxt   = 1'b1;
          pc_nxt    = pc + ADDR_W'(4);
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (redirect_valid) begin
          pc_nxt    = redir_pc;
          vld_nxt   = 1'b0;
          state_nxt = REQ;
        end else if (out_ready) begin
          vld_nxt   = 1'b0;
          state_nxt = REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_nxt = redir_pc;
        if (imem_rsp_valid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed cycle-by-cycle bench for pc_fetch_stage; imem and decode are driven inline.
module tb_pc_fetch_stage;

  localparam int AW = 32;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_instr;
  logic          out_ready;

  int n_chk = 0;
  int n_err = 0;

  pc_fetch_stage #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // From REQ at address a: handshake, 1-cycle response, present, accept.
  task automatic fetch_one(input string tag, input logic [AW-1:0] a);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd1);
    chk({tag, "_req_addr"}, 64'(imem_req_addr), 64'(a));
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk({tag, "_wait_no_req"}, 64'(imem_req_valid), 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word(a);
    tick();
    imem_rsp_valid = 1'b0;
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_out_pc"}, 64'(out_pc), 64'(a));
    chk({tag, "_out_instr"}, 64'(out_instr), 64'(word(a)));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_out_clear"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", 64'(imem_req_addr), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    rst_n = 1'b1;
    tick();  // IDLE bubble
    // 1: sequential fetches
    fetch_one("seq0", 32'h0);
    fetch_one("seq4", 32'h4);
    fetch_one("seq8", 32'h8);
    // 2: imem stall, address held
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", 64'(imem_req_valid), 64'd1);
      chk("stall_req_addr", 64'(imem_req_addr), 64'hC);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("stall_one_hs", 64'(imem_req_valid), 64'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hC0DE000C;
    tick();
    imem_rsp_valid = 1'b0;
    // 3: decode backpressure
    for (int i = 0; i < 4; i++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_pc", 64'(out_pc), 64'hC);
      chk("bp_out_instr", 64'(out_instr), 64'hC0DE000C);
      chk("bp_no_req", 64'(imem_req_valid), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_next_addr", 64'(imem_req_addr), 64'h10);
    // 4: redirect in WAIT before response
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("drain_no_req", 64'(imem_req_valid), 64'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk("drain_dropped", 64'(out_valid), 64'd0);
    fetch_one("redir100", 32'h100);
    // 5: redirect coincident with response; redirect flushes OUT
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBADBAD00;
    tick();
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    chk("coinc_dropped", 64'(out_valid), 64'd0);
    chk("coinc_req_valid", 64'(imem_req_valid), 64'd1);
    chk("coinc_addr", 64'(imem_req_addr), 64'h200);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hC0DE0200;
    tick();
    imem_rsp_valid = 1'b0;
    chk("out200_pc", 64'(out_pc), 64'h200);
    redirect_valid = 1'b1; redirect_pc = 32'h300; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; out_ready = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_addr", 64'(imem_req_addr), 64'h300);
    // 6: redirect in REQ without handshake, then wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    tick();
    redirect_valid = 1'b0;
    fetch_one("wrap", 32'hFFFFFFFC);
    chk("wrap_addr", 64'(imem_req_addr), 64'h0);
    // redirect with handshake in REQ -> drain
    imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b0;
    chk("reqhs_drain_no_req", 64'(imem_req_valid), 64'd0);
    chk("reqhs_drain_addr", 64'(imem_req_addr), 64'h40);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h11111111;
    tick();
    imem_rsp_valid = 1'b0;
    chk("reqhs_dropped", 64'(out_valid), 64'd0);
    fetch_one("f40", 32'h40);
    // reset in WAIT, late response ignored
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("mid_rst_addr", 64'(imem_req_addr), 64'h0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_pc", 64'(out_pc), 64'd0);
    chk("mid_rst_out_instr", 64'(out_instr), 64'd0);
    tick();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h22222222;
    tick();
    imem_rsp_valid = 1'b0;
    chk("late_rsp_ignored", 64'(out_valid), 64'd0);
    chk("post_rst_req", 64'(imem_req_valid), 64'd1);
    chk("post_rst_addr", 64'(imem_req_addr), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
